// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - three-stage post-normalize, round-to-nearest-even and binary32 pack pipeline
module fp_normalize_round #(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  input  logic        in_guard,
  input  logic        in_sticky,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_inexact
);

  typedef enum logic [1:0] {CLS_NORM, CLS_CARRY, CLS_ZERO, CLS_SPECIAL} cls_e;

  // stage 1 registers
  logic        r1_valid, r1_sign, r1_guard, r1_sticky;
  logic [7:0]  r1_exp;
  logic [24:0] r1_mant;
  logic [4:0]  r1_lz;
  cls_e        r1_cls;
  // stage 2 registers
  logic        r2_valid, r2_sign, r2_g, r2_s;
  logic [23:0] r2_m;
  logic signed [9:0] r2_e;
  cls_e        r2_cls;
  // stage 3 registers (drive the outputs directly)
  logic        r3_valid, r3_ovf, r3_unf, r3_inx;
  logic [31:0] r3_result;

  logic        w_rdy1, w_rdy2, w_rdy3;
  logic [4:0]  w_lz;
  cls_e        w_cls;
  logic [24:0] w_sh;
  logic [23:0] w_m2;
  logic        w_g2, w_s2;
  logic signed [9:0] w_e2;
  logic        w_inc;
  logic [24:0] w_sum;
  logic [23:0] w_m3;
  logic signed [9:0] w_e3;
  logic [31:0] w_res3;
  logic        w_ovf3, w_unf3, w_inx3;

  // A stage accepts when it is empty or its contents move on this cycle.
  assign w_rdy3   = !r3_valid | out_ready;
  assign w_rdy2   = !r2_valid | w_rdy3;
  assign w_rdy1   = !r1_valid | w_rdy2;
  assign in_ready = w_rdy1;

  // Leading-zero count of the hidden bit and fraction; 24 when all clear.
  always_comb begin
    w_lz = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (in_mant[i]) w_lz = 5'(23 - i);
    end
  end

  // Classify the incoming word; special exponents win over everything else.
  always_comb begin
    w_cls = CLS_NORM;
    if (in_exp == 8'hFF)                                   w_cls = CLS_SPECIAL;
    else if (in_mant[24])                                  w_cls = CLS_CARRY;
    else if (in_mant == 25'd0 && !in_guard && !in_sticky)  w_cls = CLS_ZERO;
  end

  // Stage 1: capture the raw sum together with its class and lz.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0; r1_sign <= 1'b0; r1_guard <= 1'b0; r1_sticky <= 1'b0;
      r1_exp <= '0; r1_mant <= '0; r1_lz <= '0; r1_cls <= CLS_NORM;
    end else if (w_rdy1) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign <= in_sign; r1_guard <= in_guard; r1_sticky <= in_sticky;
        r1_exp <= in_exp; r1_mant <= in_mant; r1_lz <= w_lz; r1_cls <= w_cls;
      end
    end
  end

  assign w_sh = {r1_mant[23:0], r1_guard} << r1_lz;

  // Renormalize: right by one on carry-out, left by lz on cancellation.
  always_comb begin
    w_m2 = '0;
    w_g2 = 1'b0;
    w_s2 = 1'b0;
    w_e2 = '0;
    case (r1_cls)
      CLS_CARRY: begin
        w_m2 = r1_mant[24:1];
        w_g2 = r1_mant[0];
        w_s2 = r1_guard | r1_sticky;
        w_e2 = $signed({2'b00, r1_exp}) + 10'sd1;
      end
      CLS_NORM: begin
        w_m2 = w_sh[24:1];
        w_g2 = w_sh[0];
        w_s2 = r1_sticky;
        w_e2 = $signed({2'b00, r1_exp}) - $signed({5'b00000, r1_lz});
      end
      CLS_SPECIAL: w_m2 = {1'b0, r1_mant[22:0]};
      default: w_m2 = '0;
    endcase
  end

  // Stage 2: hold the normalized mantissa, round bits and signed exponent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0; r2_sign <= 1'b0; r2_g <= 1'b0; r2_s <= 1'b0;
      r2_m <= '0; r2_e <= '0; r2_cls <= CLS_NORM;
    end else if (w_rdy2) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sign <= r1_sign; r2_g <= w_g2; r2_s <= w_s2;
        r2_m <= w_m2; r2_e <= w_e2; r2_cls <= r1_cls;
      end
    end
  end

  assign w_inc = ROUND_EN & r2_g & (r2_s | r2_m[0]);
  assign w_sum = {1'b0, r2_m} + {24'd0, w_inc};
  assign w_m3  = w_sum[24] ? 24'h800000 : w_sum[23:0];
  assign w_e3  = w_sum[24] ? r2_e + 10'sd1 : r2_e;

  // Pack the rounded result; specials and zeros bypass range checks.
  always_comb begin
    w_res3 = {r2_sign, 31'd0};
    w_ovf3 = 1'b0;
    w_unf3 = 1'b0;
    w_inx3 = 1'b0;
    if (r2_cls == CLS_SPECIAL) begin
      w_res3 = {r2_sign, 8'hFF, r2_m[22:0]};
    end else if (r2_cls == CLS_ZERO) begin
      w_res3 = {r2_sign, 31'd0};
    end else if (w_e3 <= 10'sd0) begin
      w_unf3 = 1'b1;
      w_inx3 = 1'b1;
    end else if (w_e3 >= 10'sd255) begin
      w_res3 = {r2_sign, 8'hFF, 23'd0};
      w_ovf3 = 1'b1;
      w_inx3 = 1'b1;
    end else begin
      w_res3 = {r2_sign, w_e3[7:0], w_m3[22:0]};
      w_inx3 = r2_g | r2_s;
    end
  end

  // Stage 3: result and flags, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_valid <= 1'b0; r3_result <= '0;
      r3_ovf <= 1'b0; r3_unf <= 1'b0; r3_inx <= 1'b0;
    end else if (w_rdy3) begin
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r3_result <= w_res3;
        r3_ovf <= w_ovf3; r3_unf <= w_unf3; r3_inx <= w_inx3;
      end
    end
  end

  assign out_valid     = r3_valid;
  assign out_result    = r3_result;
  assign out_overflow  = r3_ovf;
  assign out_underflow = r3_unf;
  assign out_inexact   = r3_inx;

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - self-checking bench for fp_normalize_round
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_mant = '0;
  logic        in_guard = 1'b0;
  logic        in_sticky = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_overflow, out_underflow, out_inexact;

  fp_normalize_round dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_guard(in_guard), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
  } out_t;

  typedef struct {
    bit        sign;
    bit [7:0]  exp;
    bit [24:0] mant;
    bit        g;
    bit        s;
    bit [31:0] res;
    bit        ovf;
    bit        unf;
    bit        inx;
    string     name;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  out_t exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference: value-level renormalize and round-half-to-even.
  function automatic out_t model(input bit sign, input bit [7:0] exp, input bit [24:0] mant,
                                 input bit g, input bit s);
    out_t   o;
    longint v, t, m;
    int     e, lz, sh, gg, ss, rem, up;
    o = '0;
    if (exp == 8'hFF) begin
      o.res = {sign, 8'hFF, mant[22:0]};
      return o;
    end
    if (mant == 25'd0 && !g && !s) begin
      o.res = {sign, 31'd0};
      return o;
    end
    v = (longint'(mant) << 1) | longint'(g);
    if (mant[24]) begin
      sh = 1;
      e  = int'(exp) + 1;
    end else begin
      lz = 0;
      while (lz < 24 && mant[23 - lz] == 1'b0) lz++;
      sh = lz + 2;
      e  = int'(exp) - lz;
    end
    t   = (v << sh) & ((longint'(1) << 27) - 1);
    m   = t >> 3;
    gg  = int'((t >> 2) & 1);
    ss  = ((t & 3) != 0 || s) ? 1 : 0;
    rem = gg * 2 + ss;
    up  = (rem > 2 || (rem == 2 && (m & 1) == 1)) ? 1 : 0;
    m   = m + longint'(up);
    if (m == (longint'(1) << 24)) begin
      m = longint'(1) << 23;
      e++;
    end
    if (e <= 0) begin
      o.res = {sign, 31'd0}; o.unf = 1'b1; o.inx = 1'b1;
    end else if (e >= 255) begin
      o.res = {sign, 8'hFF, 23'd0}; o.ovf = 1'b1; o.inx = 1'b1;
    end else begin
      o.res = {sign, 8'(e), 23'(m)};
      o.inx = (gg != 0 || ss != 0);
    end
    return o;
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  initial begin
    bit   hold_v;
    out_t hold_o, cur;
    hold_v = 1'b0;
    hold_o = '0;
    forever begin
      @(negedge clk);
      cur = {out_result, out_overflow, out_underflow, out_inexact};
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("stall_valid", 64'(out_valid), 64'(1));
          check("stall_hold", 64'(cur), 64'(hold_o));
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got %h want no output", cur);
          end else begin
            check("scoreboard", 64'(cur), 64'(exp_q.pop_front()));
          end
        end
        if (in_valid && in_ready)
          exp_q.push_back(model(in_sign, in_exp, in_mant, in_guard, in_sticky));
        hold_v = out_valid && !out_ready;
        hold_o = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Present one word at posedge+1 and return once it has been accepted.
  task automatic send(input bit sg, input bit [7:0] ex, input bit [24:0] mn,
                      input bit gd, input bit st);
    bit ok;
    in_valid = 1'b1; in_sign = sg; in_exp = ex; in_mant = mn; in_guard = gd; in_sticky = st;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    check("send_accept", 64'(ok), 64'(1));
  endtask

  task automatic run_vec(input vec_t v);
    int   lat;
    out_t want;
    send(v.sign, v.exp, v.mant, v.g, v.s);
    lat = 1;
    forever begin
      @(negedge clk);
      if (out_valid || lat >= 10) break;
      @(posedge clk);
      lat++;
    end
    check({v.name, "_latency"}, 64'(lat), 64'(3));
    want = {v.res, v.ovf, v.unf, v.inx};
    check(v.name, 64'({out_result, out_overflow, out_underflow, out_inexact}), 64'(want));
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input bit sg, input bit [7:0] ex, input bit [24:0] mn,
                               input bit gd, input bit st, input bit [31:0] r,
                               input bit ov, input bit un, input bit ix, input string nm);
    vec_t v;
    v.sign = sg; v.exp = ex; v.mant = mn; v.g = gd; v.s = st;
    v.res = r; v.ovf = ov; v.unf = un; v.inx = ix; v.name = nm;
    return v;
  endfunction

  task automatic rand_word(output bit sg, output bit [7:0] ex, output bit [24:0] mn,
                           output bit gd, output bit st);
    int k;
    sg = 1'($urandom);
    case ($urandom % 6)
      0:       ex = 8'hFF;
      1:       ex = 8'hFE;
      2:       ex = 8'($urandom % 30);
      default: ex = 8'($urandom);
    endcase
    case ($urandom % 8)
      0: mn = {1'b1, 24'($urandom)};
      1: mn = 25'd0;
      2: mn = 25'($urandom);
      default: begin
        k  = int'($urandom_range(0, 23));
        mn = (25'd1 << k) | (25'($urandom) & ((25'd1 << k) - 25'd1));
      end
    endcase
    gd = 1'($urandom);
    st = 1'($urandom);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    vec_t tbl[$];
    vec_t rv;
    bit   prod_done;
    int   base;

    tbl.push_back(mkv(0, 127, 25'h1000000, 0, 0, 32'h40000000, 0, 0, 0, "carry"));
    tbl.push_back(mkv(0, 127, 25'h0000001, 0, 0, 32'h34000000, 0, 0, 0, "cancel_lz23"));
    tbl.push_back(mkv(0,  10, 25'h0000001, 0, 0, 32'h00000000, 0, 1, 1, "cancel_underflow"));
    tbl.push_back(mkv(0, 127, 25'h0800001, 1, 0, 32'h3F800002, 0, 0, 1, "round_up_odd"));
    tbl.push_back(mkv(0, 127, 25'h0800000, 1, 0, 32'h3F800000, 0, 0, 1, "tie_even"));
    tbl.push_back(mkv(0, 127, 25'h0FFFFFF, 1, 1, 32'h40000000, 0, 0, 1, "round_carry"));
    tbl.push_back(mkv(0, 254, 25'h1000000, 0, 0, 32'h7F800000, 1, 0, 1, "overflow"));
    tbl.push_back(mkv(0, 255, 25'h0C00000, 0, 0, 32'h7FC00000, 0, 0, 0, "special"));
    tbl.push_back(mkv(1, 100, 25'h0000000, 0, 0, 32'h80000000, 0, 0, 0, "neg_zero"));
    tbl.push_back(mkv(1, 127, 25'h0800000, 0, 0, 32'hBF800000, 0, 0, 0, "neg_one"));
    tbl.push_back(mkv(0,   1, 25'h0400000, 0, 0, 32'h00000000, 0, 1, 1, "exp_zero_edge"));
    tbl.push_back(mkv(0,   1, 25'h0800000, 0, 0, 32'h00800000, 0, 0, 0, "exp_one_edge"));
    tbl.push_back(mkv(0, 127, 25'h1000001, 0, 0, 32'h40000000, 0, 0, 1, "carry_tie"));
    tbl.push_back(mkv(0, 254, 25'h0FFFFFF, 1, 1, 32'h7F800000, 1, 0, 1, "round_overflow"));
    tbl.push_back(mkv(0, 127, 25'h0000000, 1, 0, 32'h33800000, 0, 0, 0, "guard_only"));

    // reset state
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_result", 64'(out_result), 64'(0));
    check("rst_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vectors
    foreach (tbl[i]) run_vec(tbl[i]);

    // backpressure: fill with out_ready low, then toggle it
    out_ready = 1'b0;
    base = n_out;
    for (int i = 0; i < 3; i++) begin
      rand_word(rv.sign, rv.exp, rv.mant, rv.g, rv.s);
      send(rv.sign, rv.exp, rv.mant, rv.g, rv.s);
    end
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_out_valid", 64'(out_valid), 64'(1));
    out_ready = 1'b1;
    #1;
    check("full_passthru_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          bit sg, gd, st; bit [7:0] ex; bit [24:0] mn;
          rand_word(sg, ex, mn, gd, st);
          send(sg, ex, mn, gd, st);
        end
      end
      begin
        for (int c = 0; c < 20; c++) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    drain("bp_drain");
    check("bp_count", 64'(n_out - base), 64'(5));

    // reset with three words in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 8'd127, 25'h0900000 + 25'(i), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_result", 64'(out_result), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    exp_q.delete();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_vec(mkv(0, 128, 25'h0C00000, 0, 0, 32'h40400000, 0, 0, 0, "post_reset"));

    // randomized traffic with random backpressure
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          bit sg, gd, st; bit [7:0] ex; bit [24:0] mn;
          repeat ($urandom % 3) begin
            @(posedge clk);
            #1;
          end
          rand_word(sg, ex, mn, gd, st);
          send(sg, ex, mn, gd, st);
        end
        prod_done = 1'b1;
      end
      begin
        while (!prod_done) begin
          @(posedge clk);
          #1;
          out_ready = (($urandom % 10) < 7);
        end
        out_ready = 1'b1;
      end
    join
    drain("random_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
